// File: rtl/thrd_cmd_arbiter_pkg.sv
// Shared inter-CPU thread command header: manager command codes, arbiter FSM encoding, result bit index.
// Pure declarations; no latency or backpressure of its own.
package thrd_cmd_arbiter_pkg;

   typedef enum logic [3:0] {
      THREAD_CMD_NULL           = 4'h0,
      THREAD_CMD_RUN            = 4'h1,
      THREAD_CMD_STOP           = 4'h2,
      THREAD_CMD_GET_NEXT_STATE = 4'h3
   } thrd_cmd_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_ACK   = 2'd3
   } arb_state_t;

   localparam int THRD_RSLT_OK = 0;

   // wide enough for RSP_LAT-1 with RSP_LAT up to 7
   localparam int WAIT_CNT_W = 3;

   // idx mod n for 0 <= idx < 2n
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/thrd_cmd_arbiter_rr_arbiter.sv
// Round-robin picker: lowest requesting index at or after ptr, with wrap; one-hot grant plus index.
// Purely combinational (zero latency); no backpressure, the caller decides when to take the grant.
module rr_arbiter
   import thrd_cmd_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = rr_wrap(int'(ptr) + i, NUM_REQ);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/thrd_cmd_arbiter.sv
// Round-robin RUN/STOP arbiter in front of the threads manager, plus the GET_NEXT_STATE quantum timer (THRD_ARB_QUANTUM_EN).
// Request-to-ack RSP_LAT+2 cycles; one command in flight, other requestors hold req_valid until their ack.
module thrd_cmd_arbiter
   import thrd_cmd_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int RSP_LAT = 1,
   parameter int QUANTUM = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_stop,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      ack_ok,
   output logic [DATA_W-1:0]         ack_data,
   output logic [3:0]                thrd_cmd,
   output logic [DATA_W-1:0]         thrd_data,
   output logic [ADDR_W-1:0]         thrd_addr,
   input  logic [1:0]                thrd_rslt,
   input  logic [DATA_W-1:0]         mgr_data,
   output logic                      busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(RSP_LAT - 1);

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       rr_ptr_q;
   logic [IDX_W-1:0]       gnt_idx_q;
   logic [NUM_REQ-1:0]     gnt_oh_q;
   logic [WAIT_CNT_W-1:0]  wait_cnt_q;
   logic                   issue_tick_q;
   logic                   tick_pend;

   logic [NUM_REQ-1:0]     arb_gnt;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_any;

   thrd_cmd_t              cmd_d;
   logic [NUM_REQ-1:0]     ack_d;
   logic                   take_grant;
   logic                   take_rslt;

   // only the OK bit of the manager result is reported upstream
   logic                   rslt_unused;
   assign rslt_unused = thrd_rslt[1];

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (arb_gnt),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ARB_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:  if (tick_pend || arb_any) state_d = ARB_ISSUE;
         ARB_ISSUE: state_d = issue_tick_q ? ARB_IDLE : ARB_WAIT;
         ARB_WAIT:  if (wait_cnt_q == '0) state_d = ARB_ACK;
         ARB_ACK:   state_d = ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   // next values for the registered outputs: the command register loads as ISSUE is entered
   always_comb begin
      cmd_d      = THREAD_CMD_NULL;
      ack_d      = '0;
      take_grant = 1'b0;
      take_rslt  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (tick_pend) begin
               cmd_d = THREAD_CMD_GET_NEXT_STATE;
            end else if (arb_any) begin
               cmd_d      = req_stop[arb_idx] ? THREAD_CMD_STOP : THREAD_CMD_RUN;
               take_grant = 1'b1;
            end
         end
         ARB_WAIT: begin
            if (wait_cnt_q == '0) begin
               take_rslt = 1'b1;
               ack_d     = gnt_oh_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thrd_cmd     <= THREAD_CMD_NULL;
         thrd_data    <= '0;
         thrd_addr    <= '0;
         ack          <= '0;
         ack_ok       <= 1'b0;
         ack_data     <= '0;
         rr_ptr_q     <= '0;
         gnt_idx_q    <= '0;
         gnt_oh_q     <= '0;
         wait_cnt_q   <= '0;
         issue_tick_q <= 1'b0;
      end else begin
         thrd_cmd <= cmd_d;
         ack      <= ack_d;
         if (state_q == ARB_IDLE) issue_tick_q <= tick_pend;
         if (take_grant) begin
            gnt_idx_q <= arb_idx;
            gnt_oh_q  <= arb_gnt;
            thrd_data <= req_data[int'(arb_idx)*DATA_W +: DATA_W];
            thrd_addr <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
         end
         if (state_q == ARB_ISSUE)
            wait_cnt_q <= WAIT_INIT;
         else if (state_q == ARB_WAIT && wait_cnt_q != '0)
            wait_cnt_q <= wait_cnt_q - 1'b1;
         if (take_rslt) begin
            ack_ok   <= thrd_rslt[THRD_RSLT_OK];
            ack_data <= mgr_data;
         end
         if (state_q == ARB_ACK)
            rr_ptr_q <= IDX_W'(rr_wrap(int'(gnt_idx_q) + 1, NUM_REQ));
      end
   end

`ifdef THRD_ARB_QUANTUM_EN
   localparam int QCNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

   logic [QCNT_W-1:0] q_cnt_q;
   logic              tick_pend_q;
   logic              q_wrap;
   logic              tick_clr;

   assign q_wrap   = (q_cnt_q == QCNT_W'(QUANTUM - 1));
   assign tick_clr = (state_q == ARB_IDLE) && tick_pend_q;

   // a wrap landing on the same edge as the clear keeps the tick pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_cnt_q     <= '0;
         tick_pend_q <= 1'b0;
      end else begin
         q_cnt_q <= q_wrap ? '0 : q_cnt_q + 1'b1;
         if (q_wrap)        tick_pend_q <= 1'b1;
         else if (tick_clr) tick_pend_q <= 1'b0;
      end
   end

   assign tick_pend = tick_pend_q;
`else
   // scheduling advance comes from outside; QUANTUM has no effect in this build
   localparam int quantum_unused = QUANTUM;
   assign tick_pend = 1'b0;
`endif

   assign busy = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_thrd_cmd_arbiter.sv
// Scoreboard bench for thrd_cmd_arbiter: directed requests push expected commands/acks, a negedge monitor pops and compares.
// Quantum-timer scenarios run when THRD_ARB_QUANTUM_EN is defined, request scenarios otherwise.
module tb_thrd_cmd_arbiter;
   import thrd_cmd_arbiter_pkg::*;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [NR-1:0]  req_valid, req_stop, ack;
   logic [NR*DW-1:0] req_data;
   logic [NR*AW-1:0] req_addr;
   logic           ack_ok, busy;
   logic [DW-1:0]  ack_data, thrd_data, mgr_data;
   logic [AW-1:0]  thrd_addr;
   logic [3:0]     thrd_cmd;
   logic [1:0]     thrd_rslt;

   logic [1:0]     mgr_rslt;
   logic           mgr_fix_en;
   logic [31:0]    mgr_fix;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int n;

   typedef struct { int cyc; logic [3:0] cmd; logic [31:0] data; logic [31:0] addr; bit chk_dat; } exp_cmd_t;
   typedef struct { int cyc; logic [3:0] oh; logic ok; logic [31:0] data; } exp_ack_t;
   exp_cmd_t cmd_q[$];
   exp_ack_t ack_q[$];
   exp_cmd_t mc;
   exp_ack_t ma;

   thrd_cmd_arbiter #(
      .NUM_REQ (NR), .DATA_W (DW), .ADDR_W (AW), .RSP_LAT (1), .QUANTUM (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_stop  (req_stop),
      .req_data  (req_data),
      .req_addr  (req_addr),
      .ack       (ack),
      .ack_ok    (ack_ok),
      .ack_data  (ack_data),
      .thrd_cmd  (thrd_cmd),
      .thrd_data (thrd_data),
      .thrd_addr (thrd_addr),
      .thrd_rslt (thrd_rslt),
      .mgr_data  (mgr_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_cmd(input int c, input logic [3:0] cmd, input logic [31:0] d, input logic [31:0] a, input bit chk);
      exp_cmd_t e;
      e.cyc = c; e.cmd = cmd; e.data = d; e.addr = a; e.chk_dat = chk;
      cmd_q.push_back(e);
   endtask

   task automatic push_ack(input int c, input logic [3:0] oh, input logic ok, input logic [31:0] d);
      exp_ack_t e;
      e.cyc = c; e.oh = oh; e.ok = ok; e.data = d;
      ack_q.push_back(e);
   endtask

   // one cycle; requestors drop req_valid as soon as they see their ack
   task automatic tick();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~ack;
   endtask

   task automatic set_req(input int i, input logic stop, input logic [31:0] d, input logic [31:0] a);
      req_stop[i]         = stop;
      req_data[i*DW +: DW] = d;
      req_addr[i*AW +: AW] = a;
      req_valid[i]        = 1'b1;
   endtask

   // manager model: answers one cycle after each command pulse
   always @(negedge clk) begin
      if (thrd_cmd != THREAD_CMD_NULL) begin
         thrd_rslt = mgr_rslt;
         mgr_data  = mgr_fix_en ? mgr_fix : (32'hA500_0000 | thrd_addr);
      end
   end

   always @(negedge clk) begin
      if (thrd_cmd != THREAD_CMD_NULL) begin
         if (cmd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd: got cmd 0x%0h addr 0x%0h at cycle %0d, none expected", thrd_cmd, thrd_addr, cyc);
         end else begin
            mc = cmd_q.pop_front();
            check("cmd_cycle", cyc, mc.cyc);
            check("cmd_code", {28'd0, thrd_cmd}, {28'd0, mc.cmd});
            if (mc.chk_dat) begin
               check("cmd_data", thrd_data, mc.data);
               check("cmd_addr", thrd_addr, mc.addr);
            end
         end
      end
      if (ack != '0) begin
         if (ack_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: got ack 0x%0h at cycle %0d, none expected", ack, cyc);
         end else begin
            ma = ack_q.pop_front();
            check("ack_cycle", cyc, ma.cyc);
            check("ack_onehot", {28'd0, ack}, {28'd0, ma.oh});
            check("ack_ok", {31'd0, ack_ok}, {31'd0, ma.ok});
            check("ack_data", ack_data, ma.data);
         end
      end
   end

   initial begin
      rst = 1'b0; req_valid = '0; req_stop = '0; req_data = '0; req_addr = '0;
      thrd_rslt = 2'b00; mgr_data = '0; mgr_rslt = 2'b01; mgr_fix_en = 1'b0; mgr_fix = '0;
      #2 rst = 1'b1;
      #1;
      check("rst_ack", {28'd0, ack}, 32'd0);
      check("rst_cmd", {28'd0, thrd_cmd}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_thrd_data", thrd_data, 32'd0);
      check("rst_ack_data", ack_data, 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      n = cyc;

`ifdef THRD_ARB_QUANTUM_EN
      // counter wraps on edges n+10k; GET_NEXT_STATE shows the cycle after
      push_cmd(n + 11, THREAD_CMD_GET_NEXT_STATE, 0, 0, 0);
      push_cmd(n + 21, THREAD_CMD_GET_NEXT_STATE, 0, 0, 0);
      push_cmd(n + 31, THREAD_CMD_GET_NEXT_STATE, 0, 0, 0);
      push_cmd(n + 33, THREAD_CMD_RUN, 32'h11, 32'h100, 1);
      push_ack(n + 35, 4'b0001, 1'b1, 32'hA500_0100);
      push_cmd(n + 41, THREAD_CMD_GET_NEXT_STATE, 0, 0, 0);
      push_cmd(n + 48, THREAD_CMD_RUN, 32'h22, 32'h180, 1);
      push_ack(n + 50, 4'b0010, 1'b1, 32'hA500_0180);
      push_cmd(n + 52, THREAD_CMD_GET_NEXT_STATE, 0, 0, 0);
      push_cmd(n + 61, THREAD_CMD_GET_NEXT_STATE, 0, 0, 0);
      while (cyc < n + 30) tick();
      set_req(0, 1'b0, 32'h11, 32'h100);
      while (cyc < n + 47) tick();
      set_req(1, 1'b0, 32'h22, 32'h180);
      while (cyc < n + 65) tick();
`else
      // all four pending from pointer 0: grants 0,1,2,3 every 4 cycles
      mgr_rslt = 2'b01;
      for (int i = 0; i < NR; i++) begin
         set_req(i, 1'b0, 32'h1000 + i, 32'h100 + 32'h10 * i);
         push_cmd(n + 1 + 4 * i, THREAD_CMD_RUN, 32'h1000 + i, 32'h100 + 32'h10 * i, 1);
         push_ack(n + 3 + 4 * i, 4'(1 << i), 1'b1, 32'hA500_0100 + 32'h10 * i);
      end
      repeat (18) tick();

      // single RUN from requestor 0, fixed manager reply
      n = cyc;
      mgr_fix_en = 1'b1; mgr_fix = 32'hFFFF_FFFF;
      set_req(0, 1'b0, 32'h1234, 32'h100);
      push_cmd(n + 1, THREAD_CMD_RUN, 32'h1234, 32'h100, 1);
      push_ack(n + 3, 4'b0001, 1'b1, 32'hFFFF_FFFF);
      tick(); check("busy_issue", {31'd0, busy}, 32'd1);
      tick(); check("busy_wait", {31'd0, busy}, 32'd1);
      check("wait_hold_addr", thrd_addr, 32'h100);
      check("wait_hold_data", thrd_data, 32'h1234);
      tick(); check("busy_ack", {31'd0, busy}, 32'd1);
      tick(); check("busy_idle", {31'd0, busy}, 32'd0);
      repeat (2) tick();
      mgr_fix_en = 1'b0;

      // STOP from requestor 2, manager reports failure
      n = cyc;
      mgr_rslt = 2'b00;
      set_req(2, 1'b1, 32'hDEAD, 32'h200);
      push_cmd(n + 1, THREAD_CMD_STOP, 32'hDEAD, 32'h200, 1);
      push_ack(n + 3, 4'b0100, 1'b0, 32'hA500_0200);
      repeat (6) tick();

      // only result bit 0 decides ack_ok
      n = cyc;
      mgr_rslt = 2'b10;
      set_req(3, 1'b1, 32'h0, 32'h2C0);
      push_cmd(n + 1, THREAD_CMD_STOP, 32'h0, 32'h2C0, 1);
      push_ack(n + 3, 4'b1000, 1'b0, 32'hA500_02C0);
      repeat (6) tick();

      // reset during WAIT aborts without ack; the held request reruns afterwards
      n = cyc;
      mgr_rslt = 2'b01;
      set_req(0, 1'b0, 32'h7777, 32'h300);
      push_cmd(n + 1, THREAD_CMD_RUN, 32'h7777, 32'h300, 1);
      tick(); tick();
      rst = 1'b1;
      #1;
      check("abort_ack", {28'd0, ack}, 32'd0);
      check("abort_cmd", {28'd0, thrd_cmd}, 32'd0);
      check("abort_thrd_data", thrd_data, 32'd0);
      check("abort_thrd_addr", thrd_addr, 32'd0);
      check("abort_ack_data", ack_data, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      push_cmd(n + 4, THREAD_CMD_RUN, 32'h7777, 32'h300, 1);
      push_ack(n + 6, 4'b0001, 1'b1, 32'hA500_0300);
      repeat (6) tick();

      // requestor 1 drops req_valid right after its grant
      n = cyc;
      mgr_rslt = 2'b11;
      set_req(1, 1'b0, 32'h5555, 32'h180);
      push_cmd(n + 1, THREAD_CMD_RUN, 32'h5555, 32'h180, 1);
      push_ack(n + 3, 4'b0010, 1'b1, 32'hA500_0180);
      tick();
      req_valid[1] = 1'b0;
      repeat (10) tick();

      // pointer now 2: requestors 0 and 3 pending -> 3 first, then wrap to 0
      n = cyc;
      mgr_rslt = 2'b01;
      set_req(0, 1'b0, 32'hAAAA, 32'h140);
      set_req(3, 1'b0, 32'hBBBB, 32'h1C0);
      push_cmd(n + 1, THREAD_CMD_RUN, 32'hBBBB, 32'h1C0, 1);
      push_ack(n + 3, 4'b1000, 1'b1, 32'hA500_01C0);
      push_cmd(n + 5, THREAD_CMD_RUN, 32'hAAAA, 32'h140, 1);
      push_ack(n + 7, 4'b0001, 1'b1, 32'hA500_0140);
      repeat (10) tick();
`endif

      repeat (3) tick();
      check("cmd_queue_drained", cmd_q.size(), 32'd0);
      check("ack_queue_drained", ack_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/thrd_cmd_arbiter.md
Name: thrd_cmd_arbiter

Overview:
- Upstream neighbour of the threads manager. Collects RUN (fork) and STOP thread requests from NUM_REQ CPU-side requestors.
- Grants one request at a time, round-robin, and drives it onto the manager's thrd_cmd/data/addr inputs for exactly one cycle.
- Samples the manager's thrd_rslt/data_out and returns them to the granted requestor with a one-cycle ack pulse.
- Also owns the scheduling quantum timer that periodically issues THREAD_CMD_GET_NEXT_STATE.

Parameters:
- NUM_REQ, 4, number of requestors (2..8).
- DATA_W, 32, width of thread data word (matches DATA_SIZE).
- ADDR_W, 32, width of thread entry address (matches ADDR_SIZE).
- RSP_LAT, 1, cycles from thrd_cmd pulse to valid thrd_rslt/mgr_data (1..7).
- QUANTUM, 1000, cycles between GET_NEXT_STATE issues (1..65535).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requestor request pending; held high until ack.
- req_stop  in  NUM_REQ  per-requestor opcode: 0=RUN, 1=STOP.
- req_data  in  NUM_REQ*DATA_W  thread data for RUN; ignored for STOP.
- req_addr  in  NUM_REQ*ADDR_W  thread address (RUN entry / STOP target).
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- ack_ok  out  1  thrd_rslt[0] of the completed command; valid with ack.
- ack_data  out  DATA_W  manager data_out of the completed command; valid with ack.
- thrd_cmd  out  4  command to manager: THREAD_CMD_NULL/RUN/STOP/GET_NEXT_STATE.
- thrd_data  out  DATA_W  data to manager data_in.
- thrd_addr  out  ADDR_W  address to manager addr_in.
- thrd_rslt  in  2  manager result.
- mgr_data  in  DATA_W  manager data_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous and immediate:
  - ack=0, ack_ok=0, ack_data=0.
  - thrd_cmd=NULL, thrd_data=0, thrd_addr=0.
  - busy=0, FSM=IDLE, rr pointer=0, quantum counter=0, tick_pend=0.
  - Reset mid-transaction aborts it with no ack; the requestor must re-present.
- FSM states and transitions:
  - IDLE -> ISSUE if tick_pend or any req_valid; else stay.
  - ISSUE (1 cycle):
    - If tick_pend: drive GET_NEXT_STATE, clear tick_pend, go IDLE next cycle with no ack.
    - Else: latch grant index g, drive RUN or STOP with req_data[g]/req_addr[g], load wait counter = RSP_LAT-1, go WAIT.
  - WAIT: thrd_cmd=NULL, thrd_data/thrd_addr held. Counter decrements; when 0, sample thrd_rslt and mgr_data, go ACK.
  - ACK (1 cycle): ack[g]=1, ack_ok=sampled rslt[0], ack_data=sampled data. rr pointer = g+1 mod NUM_REQ. Go IDLE.
- Latency: RUN/STOP request seen in IDLE to ack = RSP_LAT+2 cycles. Minimum spacing between back-to-back grants = RSP_LAT+3 cycles.
- Outputs are registered. thrd_cmd is non-NULL for exactly one cycle per command.
- Arbitration:
  - Round-robin from the rr pointer; lowest index at or after the pointer, with wrap.
  - tick_pend has strict priority over all requests.
- Boundary cases:
  - req_valid dropped after grant: transaction still completes and ack is still pulsed.
  - req_valid high in the ACK cycle for the same requestor: treated as a new request. Requestors must deassert on ack.
  - All NUM_REQ valid: each granted once per NUM_REQ rounds; no starvation.
  - Quantum counter counts every cycle, wraps at QUANTUM-1 and sets tick_pend. If tick_pend is already set, it stays set; ticks coalesce and none queue.
  - Manager rejects RUN (thrd_rslt[0]=0, table full): reported via ack_ok=0. No retry inside this block.

Optional Feature:
- Macro THRD_ARB_QUANTUM_EN.
- Defined: quantum counter and tick_pend implemented as above.
- Undefined:
  - Counter and tick_pend are removed; GET_NEXT_STATE is never issued and QUANTUM is unused.
  - Scheduling advance is driven externally.
  - All other timing is identical.

Decomposition:
- Shared package/header (existing inter-CPU command header): THREAD_CMD_NULL/RUN/STOP/GET_NEXT_STATE codes, FSM state encodings, THRD_RSLT_OK bit index.
- One natural sub-module: rr_arbiter (NUM_REQ req vector + pointer in -> one-hot grant + index out, purely combinational). The FSM and timer stay in the top module.

Test Plan:
- Reset, then req_valid=0001 RUN, data=0x1234, addr=0x100, RSP_LAT=1, manager returns rslt=01, mgr_data=0xFFFFFFFF:
  - Cycle 1: thrd_cmd=RUN, thrd_data=0x1234, thrd_addr=0x100.
  - ack=0001 at cycle 3 with ack_ok=1, ack_data=0xFFFFFFFF.
- req_valid=1111 held, each deasserted on its ack -> grant order 0,1,2,3. Each thrd_cmd pulse is 4 cycles apart (RSP_LAT=1); exactly four acks.
- STOP from requestor 2 with addr=0x200 while manager returns rslt=00 -> thrd_cmd=STOP, thrd_addr=0x200; ack=0100 with ack_ok=0.
- THRD_ARB_QUANTUM_EN, QUANTUM=10, no requests:
  - GET_NEXT_STATE on thrd_cmd every 10 cycles, never any ack.
  - Second run with req_valid=0001 RUN raised the same cycle the counter wraps: GET_NEXT_STATE is issued first, then RUN. No tick is lost and no extra tick appears.
- Assert rst for 1 cycle while in WAIT -> all outputs return to 0/NULL immediately, no ack. Re-presented request completes normally afterwards.
- Requestor 1 drops req_valid one cycle after grant -> ack[1] still pulses once, and no second RUN is issued for requestor 1.
